mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It consumes the EX/MEM pipeline register (control bits, ALU result, store data, destination register) and runs a request/acknowledge transaction to the data memory for loads and stores. It asserts a pipeline-wide stall while a transaction is outstanding, and it registers results into the MEM/WB pipeline register. It also returns the current ALU result to the execute stage for forwarding.

## Interface
- No parameters; all widths fixed (32-bit data/address, 5-bit register address).
- clk_i  in  1  pipeline clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  global run enable; when 0, the FSM and all registers hold.
- RegWrite_i, MemToReg_i  in  1 each  from the EX/MEM register.
- MemRead_i, MemWrite_i  in  2 each  access size: 0 none, 1 byte, 2 half, 3 word.
- RegAddr_i  in  5  write-back register address.
- ALUdata_i  in  32  ALU result; doubles as the byte address.
- WriteData_i  in  32  store data.
- dmem_ack_i  in  1  memory completion, single-cycle pulse.
- dmem_rdata_i  in  32  read word; valid when dmem_ack_i=1.
- dmem_req_o  out  1  transaction request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- mem_stall_o  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- MEM_ALU_result_o  out  32  combinational copy of ALUdata_i for forwarding.
- RegWrite_o, MemToReg_o  out  1 each  MEM/WB register.
- RegAddr_o  out  5  MEM/WB register.
- ALUdata_o  out  32  MEM/WB register.
- MemData_o  out  32  MEM/WB register: aligned, sign-extended load data.
- misalign_o  out  1  sticky misaligned-access error flag.

## Operation
- **Access detection.**
  - An access is pending when MemWrite_i≠0 or MemRead_i≠0.
  - If both are nonzero, the write is performed and the read is ignored.
- **Alignment.**
  - A half access is misaligned when addr[0]=1.
  - A word access is misaligned when addr[1:0]≠0.
  - A misaligned access is not issued and causes no stall.
  - misalign_o sets and stays at 1 until reset.
  - A misaligned load's MemData_o is 0; a misaligned store's write is dropped.
  - The control bits pass through unchanged.
- **Byte enables.**
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
- **Store data.** Byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- **Load data.** Select the byte lane addr[1:0] or the half lane addr[1], then sign-extend to 32 bits. Word loads pass unchanged.
- **FSM (states IDLE, ACCESS, DONE).** All transitions are qualified by start_i=1.
  - IDLE, aligned access pending: latch address, we, be and wdata; mem_stall_o=1; go to ACCESS.
  - IDLE, no access or misaligned: mem_stall_o=0; MEM/WB loads normally; stay in IDLE.
  - ACCESS: dmem_req_o=1, driven from the latched values. mem_stall_o=1, including in the ack cycle.
  - ACCESS, dmem_ack_i=1: latch dmem_rdata_i if this is a read; go to DONE.
  - DONE: mem_stall_o=0; MEM/WB captures the latched load data and the EX/MEM inputs; go to IDLE.
  - Because EX/MEM advances at the end of DONE, a completed access is never re-issued.
- **Stalls and start_i.**
  - The MEM/WB register updates only when start_i=1 and mem_stall_o=0.
  - While stalled, MEM/WB holds its previous contents; no bubble is inserted.
  - dmem_ack_i outside ACCESS is ignored.

## Timing
- Reset (asynchronous): FSM goes to IDLE, and all registered outputs, the latches and misalign_o go to 0.
  - dmem_req_o and mem_stall_o drop in the same instant as reset assertion.
  - A reset during ACCESS abandons the transaction; a later ack is ignored.
- Non-memory instruction: MEM/WB is updated at the first edge, with a latency of 1 cycle.
- Memory access with an ack on the first ACCESS cycle:
  - IDLE→ACCESS→DONE, MEM/WB updated at the end of DONE.
  - Three cycles in the stage in total, of which mem_stall_o=1 for 2.
- Each extra wait cycle before the ack adds 1 stall cycle.
- dmem_* outputs are stable for the whole ACCESS state.
- dmem_req_o falls in the cycle after the ack.
- MEM_ALU_result_o has zero latency.

## Structure
- Package mem_pkg holds:
  - the size encodings SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state constants;
  - the byte-enable and replication helper functions.
- One sub-module, load_align: purely combinational, taking rdata, addr[1:0] and size, and producing a sign-extended 32-bit result.
- The FSM, latches and MEM/WB register live in mem_stage.

## Test plan
- Add, ALUdata_i=0x1234, RegWrite=1, no access -> no stall; next edge ALUdata_o=0x1234, RegWrite_o=1.
- lw at 0x100, ack after 2 wait cycles with rdata=0xDEADBEEF -> dmem_addr_o=0x100, be=4'hF, stall 4 cycles, MemData_o=0xDEADBEEF.
- lb at 0x103, rdata=0x80FFFFFF -> be=4'b1000, MemData_o=0xFFFFFF80; lh at 0x102, rdata=0x7FFF0000 -> MemData_o=0x00007FFF.
- sb at 0x101, WriteData_i=0x000000AB -> dmem_we_o=1, be=4'b0010, wdata=0xABABABAB, exactly one req per instruction.
- Misaligned: lw at 0x102 -> no req, no stall, misalign_o=1 and held through later instructions until rst_i.
- rst_i asserted in ACCESS, then an ack arrives after release -> req drops immediately, state is IDLE, stray ack ignored, outputs stay 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory-access pipeline stage.
package mem_pkg;

  // Access size encoding used on MemRead_i / MemWrite_i
  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  // Transaction FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Byte enables for an access of the given size at byte offset off
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes so any enabled lane sees it
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{wd[7:0]}};
      SZ_HALF: r = {2{wd[15:0]}};
      SZ_WORD: r = wd;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Natural-alignment check; byte accesses can never be misaligned
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      SZ_HALF: m = off[0];
      SZ_WORD: m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed lane of a read word and sign-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by sign extension according to access size
  always_comb begin
    case (addr_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (size_i)
      SZ_BYTE: data_o = {{24{byte_s[7]}}, byte_s};
      SZ_HALF: data_o = {{16{half_s[15]}}, half_s};
      SZ_WORD: data_o = rdata_i;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs one dmem transaction per load/store,
// stalls the front of the pipeline while it is outstanding, and holds MEM/WB.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic [1:0]  MemRead_i,
  input  logic [1:0]  MemWrite_i,
  input  logic [4:0]  RegAddr_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] WriteData_i,
  mem_stage_if.master dmem,
  output logic        mem_stall_o,
  output logic [31:0] MEM_ALU_result_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [4:0]  RegAddr_o,
  output logic [31:0] ALUdata_o,
  output logic [31:0] MemData_o,
  output logic        misalign_o
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misal_q, misal_d;
  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;
  logic [4:0]  ra_q, ra_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] md_q, md_d;

  logic [1:0]  size_s;
  logic        is_write_s;
  logic        is_read_s;
  logic        pending_s;
  logic        misal_s;
  logic        issue_s;
  logic [31:0] aligned_s;

  // Decode the EX/MEM access: a store wins over a simultaneous load
  always_comb begin
    is_write_s = (MemWrite_i != SZ_NONE);
    if (is_write_s) begin
      size_s = MemWrite_i;
    end else begin
      size_s = MemRead_i;
    end
    is_read_s = !is_write_s && (MemRead_i != SZ_NONE);
    pending_s = (size_s != SZ_NONE);
    misal_s   = pending_s && misaligned(size_s, ALUdata_i[1:0]);
    issue_s   = pending_s && !misal_s;
  end

  // EX/MEM is frozen until DONE, so its address bits still describe the latched read
  load_align u_load_align (
    .rdata_i (rdata_q),
    .addr_i  (ALUdata_i[1:0]),
    .size_i  (MemRead_i),
    .data_o  (aligned_s)
  );

  // Next-state logic for the FSM, transaction latches and MEM/WB register
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    misal_d = misal_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    ra_d    = ra_q;
    alu_d   = alu_q;
    md_d    = md_q;
    if (start_i) begin
      case (state_q)
        ST_IDLE: begin
          if (issue_s) begin
            state_d = ST_ACCESS;
            req_d   = 1'b1;
            we_d    = is_write_s;
            addr_d  = {ALUdata_i[31:2], 2'b00};
            be_d    = byte_en(size_s, ALUdata_i[1:0]);
            wdata_d = replicate(size_s, WriteData_i);
          end else begin
            // Non-memory or misaligned: pass straight through to MEM/WB
            state_d = ST_IDLE;
            misal_d = misal_q | misal_s;
            rw_d    = RegWrite_i;
            m2r_d   = MemToReg_i;
            ra_d    = RegAddr_i;
            alu_d   = ALUdata_i;
            md_d    = 32'd0;
          end
        end
        ST_ACCESS: begin
          if (dmem.ack) begin
            state_d = ST_DONE;
            req_d   = 1'b0;
            if (!we_q) begin
              rdata_d = dmem.rdata;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            state_d = ST_ACCESS;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          rw_d    = RegWrite_i;
          m2r_d   = MemToReg_i;
          ra_d    = RegAddr_i;
          alu_d   = ALUdata_i;
          if (is_read_s) begin
            md_d = aligned_s;
          end else begin
            md_d = 32'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Single register bank for FSM, transaction latches and MEM/WB
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      misal_q <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      ra_q    <= 5'd0;
      alu_q   <= 32'd0;
      md_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      misal_q <= misal_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      ra_q    <= ra_d;
      alu_q   <= alu_d;
      md_q    <= md_d;
    end
  end

  // Stall covers the issuing IDLE cycle and all of ACCESS; gated so it drops with reset
  always_comb begin
    if (!rst_i) begin
      mem_stall_o = 1'b0;
    end else if (state_q == ST_ACCESS) begin
      mem_stall_o = 1'b1;
    end else begin
      mem_stall_o = (state_q == ST_IDLE) && start_i && issue_s;
    end
  end

  assign dmem.req         = req_q;
  assign dmem.we          = we_q;
  assign dmem.addr        = addr_q;
  assign dmem.be          = be_q;
  assign dmem.wdata       = wdata_q;
  assign MEM_ALU_result_o = ALUdata_i;
  assign RegWrite_o       = rw_q;
  assign MemToReg_o       = m2r_q;
  assign RegAddr_o        = ra_q;
  assign ALUdata_o        = alu_q;
  assign MemData_o        = md_q;
  assign misalign_o       = misal_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a byte-level reference model.
module tb_mem_stage;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        RegWrite_i, MemToReg_i;
  logic [1:0]  MemRead_i, MemWrite_i;
  logic [4:0]  RegAddr_i;
  logic [31:0] ALUdata_i, WriteData_i;
  logic        mem_stall_o;
  logic [31:0] MEM_ALU_result_o;
  logic        RegWrite_o, MemToReg_o;
  logic [4:0]  RegAddr_o;
  logic [31:0] ALUdata_o, MemData_o;
  logic        misalign_o;

  mem_stage_if dmem();

  mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .RegAddr_i(RegAddr_i), .ALUdata_i(ALUdata_i), .WriteData_i(WriteData_i),
    .dmem(dmem),
    .mem_stall_o(mem_stall_o), .MEM_ALU_result_o(MEM_ALU_result_o),
    .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .RegAddr_o(RegAddr_o),
    .ALUdata_o(ALUdata_o), .MemData_o(MemData_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference view of MEM/WB and the sticky error flag
  logic        exp_rw, exp_m2r, exp_mis;
  logic [4:0]  exp_ra;
  logic [31:0] exp_alu, exp_md;

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << (int'(sz) - 1);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    int n, off;
    logic [3:0] be;
    n = nbytes(sz);
    off = (int'(a) / n) * n;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int n;
    logic [31:0] w;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] a, input logic [31:0] rd);
    int n;
    longint v, lim;
    n = nbytes(sz);
    v = longint'(rd) >> (8 * ((int'(a) / n) * n));
    lim = longint'(1) << (8 * n);
    v = v % lim;
    if (n < 4 && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  // Drive one EX/MEM instruction, play the memory, and check against the model.
  // Entered and left one time unit after a rising edge.
  task automatic run_instr(input logic rw, input logic m2r, input logic [1:0] mr,
                           input logic [1:0] mw, input logic [4:0] ra,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd, input string name);
    logic [1:0] sz;
    logic wr, pend, mis;
    logic [31:0] md;
    RegWrite_i = rw; MemToReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
    RegAddr_i = ra; ALUdata_i = alu; WriteData_i = wd;
    wr = (mw != 2'd0);
    sz = wr ? mw : mr;
    pend = (sz != 2'd0);
    mis = pend && ((int'(alu[1:0]) % nbytes(sz)) != 0);
    @(negedge clk_i);
    checks++; if (MEM_ALU_result_o !== alu) begin errors++; $display("FAIL %s fwd: got %h exp %h", name, MEM_ALU_result_o, alu); end
    if (!pend || mis) begin
      checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL %s nostall: got %b exp 0", name, mem_stall_o); end
      checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL %s noreq: got %b exp 0", name, dmem.req); end
      @(posedge clk_i); #1;
      if (pend) exp_mis = 1'b1;
      md = 32'd0;
    end else begin
      checks++; if (mem_stall_o !== 1'b1) begin errors++; $display("FAIL %s idle_stall: got %b exp 1", name, mem_stall_o); end
      checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL %s idle_req: got %b exp 0", name, dmem.req); end
      @(posedge clk_i); #1;
      for (int k = 0; k <= waits; k++) begin
        dmem.ack = (k == waits);
        dmem.rdata = (k == waits) ? rd : $urandom;
        @(negedge clk_i);
        checks++; if (dmem.req !== 1'b1) begin errors++; $display("FAIL %s req[%0d]: got %b exp 1", name, k, dmem.req); end
        checks++; if (mem_stall_o !== 1'b1) begin errors++; $display("FAIL %s stall[%0d]: got %b exp 1", name, k, mem_stall_o); end
        checks++; if (dmem.addr !== {alu[31:2], 2'b00}) begin errors++; $display("FAIL %s addr: got %h exp %h", name, dmem.addr, {alu[31:2], 2'b00}); end
        checks++; if (dmem.be !== m_be(sz, alu[1:0])) begin errors++; $display("FAIL %s be: got %b exp %b", name, dmem.be, m_be(sz, alu[1:0])); end
        checks++; if (dmem.we !== wr) begin errors++; $display("FAIL %s we: got %b exp %b", name, dmem.we, wr); end
        if (wr) begin
          checks++; if (dmem.wdata !== m_wdata(sz, wd)) begin errors++; $display("FAIL %s wdata: got %h exp %h", name, dmem.wdata, m_wdata(sz, wd)); end
        end
        checks++; if (ALUdata_o !== exp_alu || MemData_o !== exp_md) begin errors++; $display("FAIL %s wb_hold: got %h/%h exp %h/%h", name, ALUdata_o, MemData_o, exp_alu, exp_md); end
        @(posedge clk_i); #1;
        dmem.ack = 1'b0;
      end
      @(negedge clk_i);
      checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL %s done_stall: got %b exp 0", name, mem_stall_o); end
      checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL %s done_req: got %b exp 0", name, dmem.req); end
      @(posedge clk_i); #1;
      md = (!wr && mr != 2'd0) ? m_load(mr, alu[1:0], rd) : 32'd0;
    end
    exp_rw = rw; exp_m2r = m2r; exp_ra = ra; exp_alu = alu; exp_md = md;
    checks++; if (RegWrite_o !== exp_rw || MemToReg_o !== exp_m2r) begin errors++; $display("FAIL %s wb_ctl: got %b%b exp %b%b", name, RegWrite_o, MemToReg_o, exp_rw, exp_m2r); end
    checks++; if (RegAddr_o !== exp_ra) begin errors++; $display("FAIL %s wb_ra: got %0d exp %0d", name, RegAddr_o, exp_ra); end
    checks++; if (ALUdata_o !== exp_alu) begin errors++; $display("FAIL %s wb_alu: got %h exp %h", name, ALUdata_o, exp_alu); end
    checks++; if (MemData_o !== exp_md) begin errors++; $display("FAIL %s wb_md: got %h exp %h", name, MemData_o, exp_md); end
    checks++; if (misalign_o !== exp_mis) begin errors++; $display("FAIL %s misalign: got %b exp %b", name, misalign_o, exp_mis); end
  endtask

  task automatic clear_inputs();
    RegWrite_i = 1'b0; MemToReg_i = 1'b0; MemRead_i = 2'd0; MemWrite_i = 2'd0;
    RegAddr_i = 5'd0; ALUdata_i = 32'd0; WriteData_i = 32'd0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; clear_inputs();
    dmem.ack = 1'b0; dmem.rdata = 32'd0;
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (dmem.req !== 1'b0 || mem_stall_o !== 1'b0) begin errors++; $display("FAIL reset_req_stall: got %b%b exp 00", dmem.req, mem_stall_o); end
    checks++; if (RegWrite_o !== 1'b0 || MemToReg_o !== 1'b0 || RegAddr_o !== 5'd0) begin errors++; $display("FAIL reset_ctl: got %b%b%0d exp 000", RegWrite_o, MemToReg_o, RegAddr_o); end
    checks++; if (ALUdata_o !== 32'd0 || MemData_o !== 32'd0 || misalign_o !== 1'b0) begin errors++; $display("FAIL reset_data: got %h %h %b exp 0", ALUdata_o, MemData_o, misalign_o); end
    checks++; if (dmem.addr !== 32'd0 || dmem.be !== 4'd0 || dmem.we !== 1'b0) begin errors++; $display("FAIL reset_bus: got %h %b %b exp 0", dmem.addr, dmem.be, dmem.we); end
    rst_i = 1'b1;
    exp_rw = 1'b0; exp_m2r = 1'b0; exp_ra = 5'd0; exp_alu = 32'd0; exp_md = 32'd0; exp_mis = 1'b0;
  endtask

  task automatic test_add();
    run_instr(1'b1, 1'b0, 2'd0, 2'd0, 5'd3, 32'h0000_1234, 32'd0, 0, 32'd0, "add");
    checks++; if (ALUdata_o !== 32'h1234 || RegWrite_o !== 1'b1) begin errors++; $display("FAIL add_wb: got %h %b exp 00001234 1", ALUdata_o, RegWrite_o); end
  endtask

  task automatic test_loads();
    run_instr(1'b1, 1'b1, 2'd3, 2'd0, 5'd4, 32'h0000_0100, 32'd0, 2, 32'hDEAD_BEEF, "lw");
    checks++; if (MemData_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h exp deadbeef", MemData_o); end
    run_instr(1'b1, 1'b1, 2'd1, 2'd0, 5'd5, 32'h0000_0103, 32'd0, 0, 32'h80FF_FFFF, "lb");
    checks++; if (MemData_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h exp ffffff80", MemData_o); end
    run_instr(1'b1, 1'b1, 2'd2, 2'd0, 5'd6, 32'h0000_0102, 32'd0, 1, 32'h7FFF_0000, "lh");
    checks++; if (MemData_o !== 32'h0000_7FFF) begin errors++; $display("FAIL lh_data: got %h exp 00007fff", MemData_o); end
  endtask

  task automatic test_store();
    run_instr(1'b0, 1'b0, 2'd0, 2'd1, 5'd0, 32'h0000_0101, 32'h0000_00AB, 1, 32'h1111_1111, "sb");
    // store with a simultaneous read request: the write wins
    run_instr(1'b0, 1'b0, 2'd3, 2'd2, 5'd0, 32'h0000_0206, 32'h0000_BEEF, 0, 32'h2222_2222, "sh_rd");
  endtask

  task automatic test_misaligned();
    run_instr(1'b1, 1'b1, 2'd3, 2'd0, 5'd7, 32'h0000_0102, 32'd0, 0, 32'd0, "lw_mis");
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_set: got %b exp 1", misalign_o); end
    run_instr(1'b1, 1'b0, 2'd0, 2'd0, 5'd8, 32'h0000_0055, 32'd0, 0, 32'd0, "after_mis");
    run_instr(1'b0, 1'b0, 2'd0, 2'd3, 5'd0, 32'h0000_0040, 32'h1234_5678, 0, 32'd0, "sw_after_mis");
  endtask

  task automatic test_start_hold();
    start_i = 1'b0;
    RegWrite_i = 1'b1; RegAddr_i = 5'd9; ALUdata_i = 32'h0000_CAFE; MemRead_i = 2'd3;
    @(negedge clk_i);
    checks++; if (MEM_ALU_result_o !== 32'h0000_CAFE) begin errors++; $display("FAIL hold_fwd: got %h exp 0000cafe", MEM_ALU_result_o); end
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b exp 0", dmem.req); end
    checks++; if (ALUdata_o !== exp_alu || RegAddr_o !== exp_ra) begin errors++; $display("FAIL hold_wb: got %h %0d exp %h %0d", ALUdata_o, RegAddr_o, exp_alu, exp_ra); end
    start_i = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] mr, mw;
    logic [31:0] alu;
    for (int i = 0; i < 40; i++) begin
      mr = 2'($urandom_range(0, 3));
      mw = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      alu = $urandom;
      run_instr(1'($urandom), 1'($urandom), mr, mw, 5'($urandom), alu, $urandom,
                $urandom_range(0, 3), $urandom, "rand");
    end
  endtask

  task automatic test_reset_in_access();
    RegWrite_i = 1'b1; MemToReg_i = 1'b1; MemRead_i = 2'd3; MemWrite_i = 2'd0;
    RegAddr_i = 5'd10; ALUdata_i = 32'h0000_0300;
    @(posedge clk_i); #1;
    checks++; if (dmem.req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b exp 1", dmem.req); end
    #1 rst_i = 1'b0;
    #1;
    checks++; if (dmem.req !== 1'b0 || mem_stall_o !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b%b exp 00", dmem.req, mem_stall_o); end
    checks++; if (misalign_o !== 1'b0 || RegWrite_o !== 1'b0) begin errors++; $display("FAIL rst_clear: got %b %b exp 0 0", misalign_o, RegWrite_o); end
    clear_inputs();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    dmem.ack = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
    @(negedge clk_i);
    checks++; if (dmem.req !== 1'b0 || mem_stall_o !== 1'b0) begin errors++; $display("FAIL stray_ack: got %b%b exp 00", dmem.req, mem_stall_o); end
    @(posedge clk_i); #1;
    dmem.ack = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (MemData_o !== 32'd0 || ALUdata_o !== 32'd0 || RegWrite_o !== 1'b0) begin errors++; $display("FAIL post_rst_wb: got %h %h %b exp 0", MemData_o, ALUdata_o, RegWrite_o); end
    checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL post_rst_req: got %b exp 0", dmem.req); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_loads();
    test_store();
    test_misaligned();
    test_start_hold();
    test_random();
    test_reset_in_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
